// File: rtl/expipe_pkg.sv
// ---------------------------------------------------------------------------
// expipe_pkg -- execution-pipeline types and constants.
//   ROB_IDX_LEN    : width of a reorder-buffer tag.
//   ROB_EXCEPT_LEN : width of an exception code.
//   N_EU           : default number of reservation stations on the CDB.
//   cdb_data_t     : one common-data-bus beat (tag, result, exception info).
// ---------------------------------------------------------------------------
package expipe_pkg;

  import len5_pkg::*;

  localparam int ROB_IDX_LEN    = 6;
  localparam int ROB_EXCEPT_LEN = 5;
  localparam int N_EU           = 4;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0]    idx;
    logic [XLEN-1:0]           data;
    logic                      except_raised;
    logic [ROB_EXCEPT_LEN-1:0] except_code;
  } cdb_data_t;

endpackage : expipe_pkg

// File: rtl/len5_pkg.sv
// ---------------------------------------------------------------------------
// len5_pkg -- core-wide constants shared by the LEN5 pipeline blocks.
//   XLEN : architectural data width of integer results.
// ---------------------------------------------------------------------------
package len5_pkg;

  localparam int XLEN = 64;

endpackage : len5_pkg

// File: rtl/cdb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_rr_arbiter -- combinational rotating-priority grant for the CDB.
//   The winner is the first requesting index at or after ptr, wrapping
//   modulo N_EU. Driving ptr with zero gives plain lowest-index priority,
//   which is how the fixed-priority build (CDB_ARB_ROUND_ROBIN_EN undefined)
//   uses this block.
// Ports:
//   req  in  N_EU   request vector
//   ptr  in  PTR_W  index holding highest priority this cycle
//   gnt  out N_EU   one-hot grant, zero when no request
// ---------------------------------------------------------------------------
module cdb_rr_arbiter #(
  parameter int N_EU  = 4,
  parameter int PTR_W = $clog2(N_EU)
) (
  input  logic [N_EU-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_EU-1:0]  gnt
);

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_EU; i++) begin
      j = int'(ptr) + i;
      if (j >= N_EU) j = j - N_EU;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule : cdb_rr_arbiter

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter -- arbitrates N_EU reservation stations onto the common data
// bus through a single registered output stage.
//   The output register is free when empty or when the ROB takes the current
//   beat; while free (and not flushing) one requester is granted in the same
//   cycle and its payload appears on cdb_* on the next cycle. A stalled beat
//   holds stable. flush_i drops the held beat without moving the pointer.
// Configuration:
//   CDB_ARB_ROUND_ROBIN_EN defined   -> round-robin with a priority pointer.
//   CDB_ARB_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   rs_valid_i / rs_ready_o           per-RS request / one-hot grant
//   rs_idx_i, rs_data_i, rs_except_*  per-RS payload
//   rob_ready_i                       ROB accepts the current beat
//   cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_o
// ---------------------------------------------------------------------------
module cdb_arbiter
  import len5_pkg::*;
  import expipe_pkg::*;
#(
  parameter int N_EU           = expipe_pkg::N_EU,
  parameter int XLEN           = len5_pkg::XLEN,
  parameter int ROB_IDX_LEN    = expipe_pkg::ROB_IDX_LEN,
  parameter int ROB_EXCEPT_LEN = expipe_pkg::ROB_EXCEPT_LEN
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [N_EU-1:0]                     rs_valid_i,
  output logic [N_EU-1:0]                     rs_ready_o,
  input  logic [N_EU-1:0][ROB_IDX_LEN-1:0]    rs_idx_i,
  input  logic [N_EU-1:0][XLEN-1:0]           rs_data_i,
  input  logic [N_EU-1:0]                     rs_except_raised_i,
  input  logic [N_EU-1:0][ROB_EXCEPT_LEN-1:0] rs_except_code_i,
  input  logic                                rob_ready_i,
  output logic                                cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0]              cdb_idx_o,
  output logic [XLEN-1:0]                     cdb_data_o,
  output logic                                cdb_except_raised_o,
  output logic [ROB_EXCEPT_LEN-1:0]           cdb_except_o
);

  localparam int PTR_W = $clog2(N_EU);

  logic            cdb_valid_q;
  cdb_data_t       cdb_q;
  logic [PTR_W-1:0] ptr;
  logic [N_EU-1:0] gnt;
  logic            free;
  logic            grant_en;
  logic            any_grant;
  cdb_data_t       win_beat;
  logic [PTR_W-1:0] win_idx;

  assign free     = !cdb_valid_q || rob_ready_i;
  // Gating with rst_i keeps the grant at zero while reset is held, even
  // though the emptied register already looks free.
  assign grant_en = free && !flush_i && !rst_i;

  cdb_rr_arbiter #(
    .N_EU  (N_EU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (rs_valid_i),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign rs_ready_o = grant_en ? gnt : '0;
  assign any_grant  = |rs_ready_o;

  // Select the winner's payload and remember its index for the pointer.
  always_comb begin
    win_beat = '0;
    win_idx  = '0;
    for (int i = 0; i < N_EU; i++) begin
      if (gnt[i]) begin
        win_beat.idx           = rs_idx_i[i];
        win_beat.data          = rs_data_i[i];
        win_beat.except_raised = rs_except_raised_i[i];
        win_beat.except_code   = rs_except_code_i[i];
        win_idx                = PTR_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else if (flush_i) begin
      cdb_valid_q <= 1'b0;
    end else if (free) begin
      cdb_valid_q <= any_grant;
      if (any_grant) cdb_q <= win_beat;
    end
  end

`ifdef CDB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (int'(win_idx) == N_EU - 1) ? '0 : win_idx + 1'b1;
    end
  end
`else
  // Fixed priority: a zero pointer makes index 0 the highest priority.
  assign ptr = '0;
`endif

  assign cdb_valid_o         = cdb_valid_q;
  assign cdb_idx_o           = cdb_q.idx;
  assign cdb_data_o          = cdb_q.data;
  assign cdb_except_raised_o = cdb_q.except_raised;
  assign cdb_except_o        = cdb_q.except_code;

endmodule : cdb_arbiter
